// File: rtl/mdio_pkg.sv
// mdio_pkg: shared constants for the clause-22 MDIO PHY slave.
//   - opcode and start-of-frame bit patterns
//   - frame field widths
//   - FSM state encodings (plain localparam constants)
//   - management register indices with special behaviour
package mdio_pkg;

  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] ST_BITS = 2'b01;

  localparam int PHYAD_W  = 5;
  localparam int REGAD_W  = 5;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 32;

  typedef logic [3:0] mdio_state_t;

  localparam mdio_state_t S_IDLE  = 4'd0;
  localparam mdio_state_t S_ST    = 4'd1;
  localparam mdio_state_t S_OP    = 4'd2;
  localparam mdio_state_t S_PHYAD = 4'd3;
  localparam mdio_state_t S_REGAD = 4'd4;
  localparam mdio_state_t S_TA    = 4'd5;
  localparam mdio_state_t S_WDATA = 4'd6;
  localparam mdio_state_t S_RDATA = 4'd7;
  localparam mdio_state_t S_SKIP  = 4'd8;

  localparam logic [REGAD_W-1:0] REG_CTRL = 5'd0;
  localparam logic [REGAD_W-1:0] REG_ID1  = 5'd2;
  localparam logic [REGAD_W-1:0] REG_ID2  = 5'd3;

  // Only write and read opcodes start a transaction; 00 and 11 are dropped.
  function automatic logic is_valid_op(input logic [1:0] op);
    return (op == OP_WR) || (op == OP_RD);
  endfunction

endpackage

// File: rtl/mdio_edge_sync.sv
// mdio_edge_sync: brings an asynchronous level into the clk domain through
// two flops and produces single-clk pulses on its rising and falling edges.
// Ports:
//   clk      in  system clock
//   RESET    in  synchronous active-high reset
//   async_in in  asynchronous input level (MDC)
//   rise     out one-clk pulse after a synchronized 0->1 transition
//   fall     out one-clk pulse after a synchronized 1->0 transition
module mdio_edge_sync (
  input  logic clk,
  input  logic RESET,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  // [0] and [1] form the synchronizer, [2] holds the previous synchronized value.
  logic [2:0] sync_reg;

  always_ff @(posedge clk) begin
    if (RESET) begin
      sync_reg <= 3'b000;
    end else begin
      sync_reg <= {sync_reg[1:0], async_in};
    end
  end

  assign rise = sync_reg[1] & ~sync_reg[2];
  assign fall = ~sync_reg[1] & sync_reg[2];

endmodule

// File: rtl/mdio_phy_slave.sv
// mdio_phy_slave: PHY-side clause-22 MDIO management slave with a
// 32 x 16 register file.
// Frames are sampled on synchronized MDC rises; read data and the drive
// enable change on synchronized MDC falls (within 3 clk of the pad edge).
// Ports:
//   clk       in   system clock, at least 4x MDC
//   RESET     in   synchronous active-high reset
//   MDC       in   management clock from the master (asynchronous)
//   MDIO_I    in   serial data from the master
//   MDIO_O    out  serial read data to the master
//   MDIO_OE   out  slave drive enable
//   CTRL_REG  out  current value of register 0
//   WR_STROBE out  one-clk pulse per committed write
//   WR_ADDR   out  register address of the last committed write
// Build option:
//   MDIO_PREAMBLE_CHECK_EN - when defined, a frame start is only accepted
//   after 32 consecutive sampled ones in IDLE.
module mdio_phy_slave
  import mdio_pkg::*;
#(
  parameter logic [PHYAD_W-1:0] PHY_ADDR = 5'd1,
  parameter logic [DATA_W-1:0]  PHY_ID1  = 16'h0022,
  parameter logic [DATA_W-1:0]  PHY_ID2  = 16'h1550,
  parameter logic [DATA_W-1:0]  CTRL_RST = 16'h1140
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic               MDC,
  input  logic               MDIO_I,
  output logic               MDIO_O,
  output logic               MDIO_OE,
  output logic [DATA_W-1:0]  CTRL_REG,
  output logic               WR_STROBE,
  output logic [REGAD_W-1:0] WR_ADDR
);

  logic mdc_rise;
  logic mdc_fall;
  logic [1:0] mdio_sync_reg;
  logic mdio_s;

  mdio_edge_sync u_mdc_sync (
    .clk      (clk),
    .RESET    (RESET),
    .async_in (MDC),
    .rise     (mdc_rise),
    .fall     (mdc_fall)
  );

  // Same two-flop latency as MDC, so data and clock stay aligned.
  always_ff @(posedge clk) begin
    if (RESET) begin
      mdio_sync_reg <= 2'b00;
    end else begin
      mdio_sync_reg <= {mdio_sync_reg[0], MDIO_I};
    end
  end

  assign mdio_s = mdio_sync_reg[1];

  mdio_state_t          state_reg;
  logic [4:0]           bit_cnt_reg;
  logic [DATA_W-1:0]    shift_reg;
  logic [1:0]           op_reg;
  logic [REGAD_W-1:0]   regad_reg;
  logic                 phy_match_reg;
  logic                 commit_reg;
  logic                 mdio_o_reg;
  logic                 mdio_oe_reg;
  logic                 wr_strobe_reg;
  logic [REGAD_W-1:0]   wr_addr_reg;

`ifdef MDIO_PREAMBLE_CHECK_EN
  localparam logic [5:0] PRE_LEN = 6'd32;
  logic [5:0] pre_cnt_reg;
`endif

  logic [DATA_W-1:0] regfile_reg  [NUM_REGS];
  logic [DATA_W-1:0] regfile_next [NUM_REGS];

  // Field values including the bit being sampled on this rise.
  logic [1:0]         op_now;
  logic [4:0]         field_now;
  logic [DATA_W-1:0]  rd_value;
  logic               soft_rst;

  assign op_now    = {shift_reg[0], mdio_s};
  assign field_now = {shift_reg[3:0], mdio_s};

  assign rd_value = (field_now == REG_ID1) ? PHY_ID1 :
                    (field_now == REG_ID2) ? PHY_ID2 :
                    regfile_reg[field_now];

  // Setting bit 15 of register 0 is a soft reset of the whole register file.
  assign soft_rst = commit_reg && (regad_reg == REG_CTRL) && shift_reg[15];

  // ---------------------------------------------------------------------
  // Register file next-state: one entry per register.
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [REGAD_W-1:0] IDX = 5'(gi);
      if (IDX == REG_CTRL) begin : g_ctrl
        // Bit 15 is self-clearing: it is never stored.
        assign regfile_next[gi] = (commit_reg && regad_reg == REG_CTRL) ?
                                  {1'b0, shift_reg[14:0]} : regfile_reg[gi];
      end else if (IDX == REG_ID1 || IDX == REG_ID2) begin : g_id
        // Read-only: reads come from the ID parameters, writes are dropped.
        assign regfile_next[gi] = '0;
      end else begin : g_rw
        assign regfile_next[gi] = soft_rst ? '0 :
                                  (commit_reg && regad_reg == IDX) ? shift_reg :
                                  regfile_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regfile_reg[i] <= (i == 0) ? CTRL_RST : '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regfile_reg[i] <= regfile_next[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Frame FSM: rises sample, falls drive.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_reg     <= S_IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      op_reg        <= '0;
      regad_reg     <= '0;
      phy_match_reg <= 1'b0;
      commit_reg    <= 1'b0;
      mdio_o_reg    <= 1'b0;
      mdio_oe_reg   <= 1'b0;
      wr_strobe_reg <= 1'b0;
      wr_addr_reg   <= '0;
`ifdef MDIO_PREAMBLE_CHECK_EN
      pre_cnt_reg   <= '0;
`endif
    end else begin
      // Commit lands one clk after the last data rise; strobe and address
      // appear together with the updated register.
      commit_reg    <= 1'b0;
      wr_strobe_reg <= commit_reg;
      if (commit_reg) begin
        wr_addr_reg <= regad_reg;
      end

`ifdef MDIO_PREAMBLE_CHECK_EN
      // Any time spent inside a frame discards the preamble count, which
      // is equivalent to clearing it at every frame end.
      if (state_reg != S_IDLE) begin
        pre_cnt_reg <= '0;
      end
`endif

      if (mdc_rise) begin
        case (state_reg)
          S_IDLE: begin
`ifdef MDIO_PREAMBLE_CHECK_EN
            if (mdio_s) begin
              if (pre_cnt_reg != PRE_LEN) begin
                pre_cnt_reg <= pre_cnt_reg + 6'd1;
              end
            end else if (pre_cnt_reg == PRE_LEN) begin
              state_reg <= S_ST;
            end else begin
              pre_cnt_reg <= '0;
            end
`else
            if (mdio_s == ST_BITS[1]) begin
              state_reg <= S_ST;
            end
`endif
          end

          S_ST: begin
            bit_cnt_reg <= '0;
            state_reg   <= (mdio_s == ST_BITS[0]) ? S_OP : S_IDLE;
          end

          S_OP: begin
            shift_reg <= {shift_reg[14:0], mdio_s};
            if (bit_cnt_reg == 5'd1) begin
              bit_cnt_reg <= '0;
              op_reg      <= op_now;
              state_reg   <= is_valid_op(op_now) ? S_PHYAD : S_IDLE;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end

          S_PHYAD: begin
            shift_reg <= {shift_reg[14:0], mdio_s};
            if (bit_cnt_reg == 5'd4) begin
              bit_cnt_reg   <= '0;
              phy_match_reg <= (field_now == PHY_ADDR);
              state_reg     <= S_REGAD;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end

          S_REGAD: begin
            if (bit_cnt_reg == 5'd4) begin
              bit_cnt_reg <= '0;
              // A foreign PHY address is acted on once REGAD has passed, so
              // that SKIP covers exactly the TA and DATA bits of the frame.
              if (!phy_match_reg) begin
                state_reg <= S_SKIP;
              end else begin
                regad_reg <= field_now;
                state_reg <= S_TA;
                shift_reg <= (op_reg == OP_RD) ? rd_value
                                               : {shift_reg[14:0], mdio_s};
              end
            end else begin
              shift_reg   <= {shift_reg[14:0], mdio_s};
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end

          S_TA: begin
            if (bit_cnt_reg == 5'd1) begin
              bit_cnt_reg <= '0;
              state_reg   <= (op_reg == OP_WR) ? S_WDATA : S_RDATA;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end

          S_WDATA: begin
            shift_reg <= {shift_reg[14:0], mdio_s};
            if (bit_cnt_reg == 5'd15) begin
              bit_cnt_reg <= '0;
              commit_reg  <= 1'b1;
              state_reg   <= S_IDLE;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end

          S_SKIP: begin
            if (bit_cnt_reg == 5'd17) begin
              bit_cnt_reg <= '0;
              state_reg   <= S_IDLE;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end

          S_RDATA: begin
            // The master is not driving; nothing to sample.
          end

          default: begin
            state_reg <= S_IDLE;
          end
        endcase
      end else if (mdc_fall) begin
        case (state_reg)
          S_TA: begin
            // Take the bus on the fall between the two TA rises.
            if (op_reg == OP_RD && bit_cnt_reg == 5'd1) begin
              mdio_oe_reg <= 1'b1;
              mdio_o_reg  <= 1'b0;
            end
          end

          S_RDATA: begin
            if (bit_cnt_reg == 5'd16) begin
              // Release on the fall after bit 0; the master may present the
              // next ST bit on this same fall.
              mdio_oe_reg <= 1'b0;
              mdio_o_reg  <= 1'b0;
              bit_cnt_reg <= '0;
              state_reg   <= S_IDLE;
            end else begin
              mdio_o_reg  <= shift_reg[15];
              shift_reg   <= {shift_reg[14:0], 1'b0};
              bit_cnt_reg <= bit_cnt_reg + 5'd1;
            end
          end

          default: begin
          end
        endcase
      end
    end
  end

  assign MDIO_O    = mdio_o_reg;
  assign MDIO_OE   = mdio_oe_reg;
  assign CTRL_REG  = regfile_reg[REG_CTRL];
  assign WR_STROBE = wr_strobe_reg;
  assign WR_ADDR   = wr_addr_reg;

endmodule

// File: tb/tb_mdio_phy_slave.sv
// tb_mdio_phy_slave: drives clause-22 frames into mdio_phy_slave and checks
// register behaviour, read serialisation, write strobes and reset against a
// register-level reference model. Honours MDIO_PREAMBLE_CHECK_EN.
module tb_mdio_phy_slave;

  localparam logic [4:0]  PHY_ADDR = 5'd1;
  localparam logic [15:0] PHY_ID1  = 16'h0022;
  localparam logic [15:0] PHY_ID2  = 16'h1550;
  localparam logic [15:0] CTRL_RST = 16'h1140;
  localparam logic [1:0]  OP_WR    = 2'b01;
  localparam logic [1:0]  OP_RD    = 2'b10;

  logic        clk = 1'b0;
  logic        RESET;
  logic        MDC;
  logic        MDIO_I;
  logic        MDIO_O;
  logic        MDIO_OE;
  logic [15:0] CTRL_REG;
  logic        WR_STROBE;
  logic [4:0]  WR_ADDR;

  int err_count   = 0;
  int check_count = 0;
  int strobe_cnt  = 0;
  int frame_no    = 0;
  logic [4:0] strobe_addr = 5'd0;

  logic [15:0] mdl_regs [32];
  logic        oe_hist  [32];
  logic        o_hist   [32];

  mdio_phy_slave #(
    .PHY_ADDR (PHY_ADDR),
    .PHY_ID1  (PHY_ID1),
    .PHY_ID2  (PHY_ID2),
    .CTRL_RST (CTRL_RST)
  ) dut (
    .clk       (clk),
    .RESET     (RESET),
    .MDC       (MDC),
    .MDIO_I    (MDIO_I),
    .MDIO_O    (MDIO_O),
    .MDIO_OE   (MDIO_OE),
    .CTRL_REG  (CTRL_REG),
    .WR_STROBE (WR_STROBE),
    .WR_ADDR   (WR_ADDR)
  );

  always #5 clk = ~clk;

  // Count strobe pulses (one per clk they are high) and log the address.
  always @(negedge clk) begin
    if (WR_STROBE === 1'b1) begin
      strobe_cnt  <= strobe_cnt + 1;
      strobe_addr <= WR_ADDR;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      err_count++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model: register-level semantics -----------
  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mdl_regs[i] = 16'h0000;
    mdl_regs[0] = CTRL_RST;
  endfunction

  function automatic void model_write(input logic [4:0] a, input logic [15:0] d);
    if (a == 5'd2 || a == 5'd3) return;
    if (a == 5'd0 && d[15]) begin
      for (int i = 0; i < 32; i++) mdl_regs[i] = 16'h0000;
      mdl_regs[0] = {1'b0, d[14:0]};
    end else begin
      mdl_regs[a] = d;
    end
  endfunction

  function automatic logic [15:0] model_read(input logic [4:0] a);
    if (a == 5'd2) return PHY_ID1;
    if (a == 5'd3) return PHY_ID2;
    return mdl_regs[a];
  endfunction

  // ---------------- MDC bit generation (80 ns per bit) ------------------
  // Data is presented on the fall and the slave outputs are sampled 38 ns
  // later, just before the rise. Optionally pulses RESET instead of rising.
  task automatic mdc_bit(input logic b, input bit do_reset,
                         output logic oe_s, output logic o_s);
    MDC    = 1'b0;
    MDIO_I = b;
    #38;
    oe_s = MDIO_OE;
    o_s  = MDIO_O;
    if (do_reset) begin
      RESET = 1'b1;
      #10;
      check_value("reset_oe", 32'(MDIO_OE), 32'd0);
      check_value("reset_ctrl", 32'(CTRL_REG), 32'(CTRL_RST));
      check_value("reset_strobe", 32'(WR_STROBE), 32'd0);
      RESET = 1'b0;
      #2;
    end else begin
      #2;
      MDC = 1'b1;
      #40;
    end
  endtask

  // One frame: preamble, 32 frame bits, then a trailing fall (no rise) on
  // which the read release is observed.
  task automatic run_frame(input int pre_len, input logic [1:0] op,
                           input logic [4:0] phyad, input logic [4:0] regad,
                           input logic [15:0] wdata, input int abort_bit);
    logic [31:0] frame;
    logic        oe_s, o_s, rel_oe, pre_ok, accepted, early_oe, any_oe;
    logic [15:0] rd_exp, rd_got;
    int          strobes0, oe_cnt;

    frame_no++;
    for (int i = 0; i < pre_len; i++) mdc_bit(1'b1, 1'b0, oe_s, o_s);

    if (op == OP_RD)      frame = {2'b01, op, phyad, regad, 18'h3FFFF};
    else if (op == OP_WR) frame = {2'b01, op, phyad, regad, 2'b10, wdata};
    else                  frame = {2'b01, op, 28'hFFFFFFF};

    strobes0 = strobe_cnt;
    for (int i = 0; i < 32; i++) begin
      mdc_bit(frame[31-i], i == abort_bit, oe_s, o_s);
      oe_hist[i] = oe_s;
      o_hist[i]  = o_s;
      if (i == abort_bit) begin
        check_value("abort_oe_before", 32'(oe_s), 32'd1);
        model_reset();
        $display("frame %0d: op=%b reg=%0d reset at frame bit %0d", frame_no, op, regad, i);
        return;
      end
    end

    MDC    = 1'b0;
    MDIO_I = 1'b1;
    #38;
    rel_oe = MDIO_OE;
    #2;

`ifdef MDIO_PREAMBLE_CHECK_EN
    pre_ok = (pre_len >= 32);
`else
    pre_ok = 1'b1;
`endif
    accepted = pre_ok && (phyad == PHY_ADDR) && (op == OP_WR || op == OP_RD);

    if (accepted && op == OP_WR) begin
      model_write(regad, wdata);
      check_value("wr_strobe_count", 32'(strobe_cnt - strobes0), 32'd1);
      check_value("wr_addr", 32'(strobe_addr), 32'(regad));
    end else begin
      check_value("no_strobe", 32'(strobe_cnt - strobes0), 32'd0);
    end

    if (accepted && op == OP_RD) begin
      rd_exp   = model_read(regad);
      early_oe = 1'b0;
      for (int i = 0; i < 15; i++) early_oe = early_oe | oe_hist[i];
      rd_got = 16'h0000;
      oe_cnt = 0;
      for (int i = 16; i < 32; i++) begin
        rd_got = {rd_got[14:0], o_hist[i]};
        if (oe_hist[i] === 1'b1) oe_cnt++;
      end
      check_value("rd_oe_before_ta2", 32'(early_oe), 32'd0);
      check_value("rd_oe_ta2", 32'(oe_hist[15]), 32'd1);
      check_value("rd_o_ta2", 32'(o_hist[15]), 32'd0);
      check_value("rd_data", 32'(rd_got), 32'(rd_exp));
      check_value("rd_oe_data", 32'(oe_cnt), 32'd16);
      check_value("rd_release", 32'(rel_oe), 32'd0);
    end else begin
      any_oe = rel_oe;
      for (int i = 0; i < 32; i++) any_oe = any_oe | oe_hist[i];
      check_value("oe_idle", 32'(any_oe), 32'd0);
    end

    check_value("ctrl_reg", 32'(CTRL_REG), 32'(mdl_regs[0]));
    $display("frame %0d: pre=%0d op=%b phy=%0d reg=%0d wdata=%h accepted=%0d ctrl=%h",
             frame_no, pre_len, op, phyad, regad, wdata, accepted, CTRL_REG);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [4:0]  r_phy;
    logic [4:0]  r_reg;
    logic [15:0] r_dat;
    int          sel;

    RESET  = 1'b1;
    MDC    = 1'b0;
    MDIO_I = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    check_value("rst_ctrl", 32'(CTRL_REG), 32'(CTRL_RST));
    check_value("rst_oe", 32'(MDIO_OE), 32'd0);
    check_value("rst_o", 32'(MDIO_O), 32'd0);
    check_value("rst_strobe", 32'(WR_STROBE), 32'd0);
    check_value("rst_wr_addr", 32'(WR_ADDR), 32'd0);
    RESET = 1'b0;
    // From here every delay is a multiple of 10 ns, so MDC edges stay on
    // clk falling edges.

    run_frame(32, OP_WR, PHY_ADDR, 5'd0, 16'h1234, -1);
    run_frame(32, OP_WR, PHY_ADDR, 5'd7, 16'hBEEF, -1);
    run_frame(32, OP_RD, PHY_ADDR, 5'd7, 16'h0000, -1);
    run_frame(32, OP_RD, PHY_ADDR, 5'd2, 16'h0000, -1);
    run_frame(32, OP_WR, PHY_ADDR, 5'd3, 16'hFFFF, -1);
    run_frame(32, OP_RD, PHY_ADDR, 5'd3, 16'h0000, -1);

    // Frames for another PHY, then a valid one.
    run_frame(32, OP_WR, 5'd2, 5'd7, 16'h1111, -1);
    run_frame(32, OP_RD, 5'd2, 5'd7, 16'h0000, -1);
    run_frame(32, OP_RD, PHY_ADDR, 5'd7, 16'h0000, -1);

    // Preamble handling: short preamble, full preamble, none at all.
    run_frame(31, OP_WR, PHY_ADDR, 5'd5, 16'h00A5, -1);
    run_frame(32, OP_WR, PHY_ADDR, 5'd5, 16'h00A5, -1);
    run_frame(0,  OP_WR, PHY_ADDR, 5'd6, 16'h0C3C, -1);
    run_frame(32, OP_RD, PHY_ADDR, 5'd5, 16'h0000, -1);

    // Soft reset through register 0 bit 15.
    run_frame(32, OP_WR, PHY_ADDR, 5'd0, 16'h9000, -1);
    run_frame(32, OP_RD, PHY_ADDR, 5'd7, 16'h0000, -1);

    // Randomized frames.
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(5, 0));
      case (sel)
        0, 1:    r_op = OP_WR;
        2, 3:    r_op = OP_RD;
        4:       r_op = 2'b00;
        default: r_op = 2'b11;
      endcase
      r_phy = ($urandom_range(3, 0) == 0) ? 5'($urandom) : PHY_ADDR;
      r_reg = 5'($urandom);
      r_dat = 16'($urandom);
      run_frame(32, r_op, r_phy, r_reg, r_dat, -1);
    end

    // Invalid opcode, then RESET during read data bit 8.
    run_frame(32, OP_WR, PHY_ADDR, 5'd9, 16'h5A5A, -1);
    run_frame(32, 2'b00, PHY_ADDR, 5'd9, 16'h0000, -1);
    run_frame(32, OP_RD, PHY_ADDR, 5'd9, 16'h0000, 24);
    run_frame(32, OP_RD, PHY_ADDR, 5'd9, 16'h0000, -1);
    run_frame(32, OP_RD, PHY_ADDR, 5'd0, 16'h0000, -1);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule

// File: doc/mdio_phy_slave.md
Name: mdio_phy_slave

Overview:
- PHY-side MDIO management slave. Directly downstream of the team's MDIO master.
- Consumes the master's MDC, MDIO_OUT and MDIO_OE, decodes clause-22 frames, and holds a 32 x 16 management register file.
- Drives read data back to the master's MDIO_IN.
- Used as the on-chip PHY model and as the register front-end of the PHY control logic.

Parameters:
- PHY_ADDR, 5'd1: PHY address this slave answers to.
- PHY_ID1, 16'h0022: read-only content of register 2.
- PHY_ID2, 16'h1550: read-only content of register 3.
- CTRL_RST, 16'h1140: reset value of register 0.

Ports:
- clk  in  1  system clock; must be at least 4x MDC.
- RESET  in  1  synchronous, active-high reset, clock clk.
- MDC  in  1  management clock from master, asynchronous to clk.
- MDIO_I  in  1  serial data from master (master MDIO_OUT, qualified by master MDIO_OE).
- MDIO_O  out  1  serial read data to master MDIO_IN.
- MDIO_OE  out  1  slave drive enable.
- CTRL_REG  out  16  current value of register 0.
- WR_STROBE  out  1  one-clk pulse on each committed write.
- WR_ADDR  out  5  register address of the last committed write.

Behaviour:
- Reset values: MDIO_O=0, MDIO_OE=0, WR_STROBE=0, WR_ADDR=0, CTRL_REG=CTRL_RST, regs 1 and 4..31 = 0, state=IDLE.
- MDC and MDIO_I pass through a 2-flop synchronizer plus edge detector.
- Sampling: all frame bits are sampled on the detected MDC rise.
- Drive: MDIO_O and MDIO_OE update on the detected MDC fall, at most 3 clk after the pad edge.
- Frame layout: ST(01), OP(2), PHYAD(5), REGAD(5), TA(2), DATA(16), MSB first. OP 01 = write, OP 10 = read.
- States: IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, SKIP. A 5-bit bit counter and a 16-bit shift register serve all states.
- IDLE: a sampled 0 moves to ST; a 1 stays in IDLE.
- ST: sampled 1 moves to OP; sampled 0 returns to IDLE.
- OP: 00 or 11 returns to IDLE with no other effect.
- PHYAD: mismatch against PHY_ADDR moves to SKIP. SKIP counts 18 rises (TA+DATA) with MDIO_OE held 0, then returns to IDLE.
- REGAD: after 5 bits, latch the address and move to TA.
- TA, write: ignore both bits, then WDATA.
- TA, read: MDIO_OE stays 0 for TA bit 1. On the MDC fall inside TA bit 2, drive MDIO_OE=1, MDIO_O=0.
- RDATA: drive data bits 15..0 on successive falls. Release MDIO_OE=0 on the fall after bit 0, then return to IDLE.
- Read data source: reg 2 = PHY_ID1, reg 3 = PHY_ID2, otherwise the register file. Data is captured into the shift register on entry to TA.
- WDATA: on the 16th rise, commit the next clk, pulse WR_STROBE for one clk and update WR_ADDR.
- Writes to regs 2 and 3 are dropped. They still pulse WR_STROBE with the addressed register in WR_ADDR.
- Write of reg 0 with bit 15 set: stores the value with bit 15 cleared (self-clearing soft reset). All other registers reset to 0.
- Back-to-back frames without idle bits are supported: IDLE is re-entered before the next ST bit.
- RESET mid-frame: next clk returns to IDLE, MDIO_OE=0, all registers reset, and no write is committed.
- Simultaneous MDC rise and fall detection cannot occur; only one edge is processed per clk.

Optional Feature:
- Macro: MDIO_PREAMBLE_CHECK_EN.
- Defined: IDLE requires 32 consecutive sampled 1s (saturating 6-bit counter) before a 0 is accepted as the ST start. A 0 seen earlier clears the counter and stays in IDLE. The counter clears on each frame end.
- Undefined: preamble suppression; any 0 in IDLE starts a frame.

Decomposition:
- Package mdio_pkg:
  - opcode constants OP_WR=2'b01, OP_RD=2'b10, ST_BITS=2'b01.
  - Field widths 5/5/16.
  - State enum for the states above.
  - Register index constants REG_CTRL=0, REG_ID1=2, REG_ID2=3.
- One sub-module, mdio_edge_sync: 2-flop synchronizer plus rise/fall pulse generator. Instantiated for MDC; MDIO_I uses a plain synchronizer.

Test Plan:
- Write frame 01_01_00001_00000_xx_0x1234 (preamble of 32 ones) -> CTRL_REG=0x1234 and one WR_STROBE with WR_ADDR=0, then write reg 7=0xBEEF.
- Read reg 7 after that write -> MDIO_OE=0 in TA bit 1. MDIO_OE=1 with MDIO_O=0 in TA bit 2. MDIO_O serialises 0xBEEF MSB first, then MDIO_OE=0.
- Read reg 2 -> 0x0022. Write 0xFFFF to reg 3, then read reg 3 -> still 0x1550.
- Frame with PHYAD=00010 -> MDIO_OE stays 0 throughout, no WR_STROBE. The next valid frame is decoded correctly.
- OP=00 frame, then assert RESET during RDATA bit 8 -> MDIO_OE=0 on the next clk and CTRL_REG=0x1140.
- MDIO_PREAMBLE_CHECK_EN defined:
  - 31 ones then a valid write -> ignored.
  - 32 ones then the same write -> committed.
  - With the macro undefined, 0 ones then the same write -> committed.
